vwb_arbiter: RTL

- Vector writeback stage directly downstream of the vector execution stage; owns the single vector-register-file (VRF) write port.
- Buffers execution-stage results, which arrive with no backpressure, in a small FIFO.
- Round-robin arbitrates those results against load-unit writebacks, presents one registered write per cycle to the VRF, and accumulates sticky FP exception flags.

---
 rtl/vwb_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vwb_arbiter.sv
// Vector writeback arbiter: buffers execution results in a small FIFO and round-robins them
// against load writebacks onto the single registered VRF write port. Optional macro: VWB_BYPASS_EN.
module vwb_arbiter #(
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES     = 8,
    parameter int XLEN             = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int STALL_THRESH     = 2,
    localparam int AW = $clog2(VECTOR_REGISTERS),
    localparam int DW = VECTOR_LANES * XLEN,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VECTOR_LANES-1:0] vex_wr_en_i,
    input  logic [AW-1:0]           vex_wr_addr_i,
    input  logic [DW-1:0]           vex_wr_data_i,
    input  logic [4:0]              vex_fflags_i,
    input  logic                    mem_valid_i,
    output logic                    mem_ready_o,
    input  logic [VECTOR_LANES-1:0] mem_wr_en_i,
    input  logic [AW-1:0]           mem_wr_addr_i,
    input  logic [DW-1:0]           mem_wr_data_i,
    input  logic                    fflags_clr_i,
    output logic [VECTOR_LANES-1:0] vrf_wr_en_o,
    output logic [AW-1:0]           vrf_wr_addr_o,
    output logic [DW-1:0]           vrf_wr_data_o,
    output logic [4:0]              fflags_o,
    output logic                    stall_o,
    output logic                    overflow_o,
    output logic                    idle_o
);

    logic [VECTOR_LANES-1:0] mask_mem [FIFO_DEPTH];
    logic [AW-1:0]           addr_mem [FIFO_DEPTH];
    logic [DW-1:0]           data_mem [FIFO_DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          prio_mem_q;
    logic          overflow_q;
    logic [4:0]    fflags_q;

    logic empty, full, push, bypass, exec_req, contend;
    logic grant_exec, grant_mem, pop, fifo_wr, drop;

    logic [VECTOR_LANES-1:0] sel_en_p0;
    logic [AW-1:0]           sel_addr_p0;
    logic [DW-1:0]           sel_data_p0;

    logic [VECTOR_LANES-1:0] en_p1;
    logic [AW-1:0]           addr_p1;
    logic [DW-1:0]           data_p1;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign push  = |vex_wr_en_i;

`ifdef VWB_BYPASS_EN
    assign bypass = push & empty;
`else
    assign bypass = 1'b0;
`endif

    // Stage p0: round-robin between the execution candidate and the load unit
    assign exec_req   = ~empty | bypass;
    assign contend    = exec_req & mem_valid_i;
    assign grant_exec = exec_req & (~mem_valid_i | ~prio_mem_q);
    assign grant_mem  = mem_valid_i & (~exec_req | prio_mem_q);
    assign pop        = grant_exec & ~empty;
    // A bypassed push that wins goes straight to the output and never occupies a slot.
    assign fifo_wr    = push & ~(grant_exec & bypass) & (~full | pop);
    assign drop       = push & full & ~pop;

    assign mem_ready_o = grant_mem;
    assign stall_o     = int'(count_q) >= (FIFO_DEPTH - STALL_THRESH);
    assign idle_o      = empty & ~mem_valid_i & ~|vrf_wr_en_o;

    always_comb begin
        sel_en_p0   = mask_mem[head_q];
        sel_addr_p0 = addr_mem[head_q];
        sel_data_p0 = data_mem[head_q];
        if (bypass) begin
            sel_en_p0   = vex_wr_en_i;
            sel_addr_p0 = vex_wr_addr_i;
            sel_data_p0 = vex_wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mask_mem[tail_q] <= vex_wr_en_i;
            addr_mem[tail_q] <= vex_wr_addr_i;
            data_mem[tail_q] <= vex_wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            prio_mem_q <= 1'b0;
            overflow_q <= 1'b0;
            fflags_q   <= '0;
        end else begin
            if (fifo_wr) tail_q <= tail_q + PW'(1);
            if (pop)     head_q <= head_q + PW'(1);
            case ({fifo_wr, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // The loser of a contention gets priority next time.
            if (contend) prio_mem_q <= grant_exec;
            if (drop)    overflow_q <= 1'b1;
            if (fflags_clr_i)
                fflags_q <= push ? vex_fflags_i : 5'd0;
            else if (push)
                fflags_q <= fflags_q | vex_fflags_i;
        end
    end

    // Stage p1: registered VRF write port
    always_ff @(posedge clk) begin
        if (rst) begin
            en_p1   <= '0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (grant_exec) begin
            en_p1   <= sel_en_p0;
            addr_p1 <= sel_addr_p0;
            data_p1 <= sel_data_p0;
        end else if (grant_mem) begin
            en_p1   <= mem_wr_en_i;
            addr_p1 <= mem_wr_addr_i;
            data_p1 <= mem_wr_data_i;
        end else begin
            en_p1   <= '0;
        end
    end

    assign vrf_wr_en_o   = en_p1;
    assign vrf_wr_addr_o = addr_p1;
    assign vrf_wr_data_o = data_p1;
    assign fflags_o      = fflags_q;
    assign overflow_o    = overflow_q;

endmodule
